// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - single-port frame-buffer arbiter for VGA scan-out, CPU access and screen clear
module fb_arbiter #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int AW    = 19
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pix_en,
  input  logic          disp_active,
  input  logic [8:0]    line,
  input  logic [9:0]    offset,
  output logic [2:0]    rgb,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [2:0]    mem_wdata,
  input  logic [2:0]    mem_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [2:0]    cpu_wdata,
  output logic          cpu_ack,
  output logic [2:0]    cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          clr_start,
  input  logic [2:0]    clr_color,
  output logic          clr_busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_CLEAR   = 2'd2;

  localparam int            FB_SIZE = H_RES * V_RES;
  localparam logic [AW-1:0] FB_LAST = AW'(FB_SIZE - 1);

  logic [1:0]    r_state;
  logic [AW-1:0] r_clr_cnt;
  logic [2:0]    r_clr_color;
  logic          r_clr_busy;
  logic          r_rd_oor;
  logic          r_disp_rd;
  logic [2:0]    r_rgb;
  logic [2:0]    r_cpu_rdata;

  logic          w_disp_slot;
  logic          w_free_slot;
  logic [19:0]   w_lin_full;
  logic [AW-1:0] w_disp_addr;
  logic          w_cpu_in_range;
  logic          w_clr_go;
  logic          w_cpu_go;
  logic          w_cpu_wr;
  logic          w_clr_wr;
  logic [2:0]    w_rd_live;
  logic [AW-1:0] w_addr;
  logic          w_we;
  logic [2:0]    w_wdata;

  // A display slot belongs to scan-out alone; every other clk is free for clear/CPU.
  assign w_disp_slot = pix_en & disp_active;
  assign w_free_slot = ~w_disp_slot;

  // line*H_RES + offset; for the standard 640-wide mode this is two shifts and an add.
  generate
    if (H_RES == 640) begin : g_shift
      assign w_lin_full = ({11'd0, line} << 9) + ({11'd0, line} << 7) + {10'd0, offset};
    end else begin : g_mult
      assign w_lin_full = ({11'd0, line} * 20'(H_RES)) + {10'd0, offset};
    end
  endgenerate
  assign w_disp_addr = AW'(w_lin_full);

  assign w_cpu_in_range = (cpu_addr <= FB_LAST);

  // Clear start beats a simultaneous CPU request; both need IDLE and a free slot.
  assign w_clr_go = (r_state == S_IDLE) & w_free_slot & clr_start;
  assign w_cpu_go = (r_state == S_IDLE) & w_free_slot & ~clr_start & cpu_req;
  assign w_cpu_wr = w_cpu_go & cpu_we & w_cpu_in_range;
  assign w_clr_wr = (r_state == S_CLEAR) & w_free_slot;

  // Out-of-range reads still complete, but always return black.
  assign w_rd_live = r_rd_oor ? 3'd0 : mem_rdata;

  // RAM port owner for this clk; the RAM's synchronous port registers the address.
  always_comb begin
    w_addr  = '0;
    w_we    = 1'b0;
    w_wdata = 3'd0;
    if (w_disp_slot) begin
      w_addr = w_disp_addr;
    end else if (w_clr_wr) begin
      w_addr  = r_clr_cnt;
      w_we    = 1'b1;
      w_wdata = r_clr_color;
    end else if (w_cpu_go) begin
      w_addr  = cpu_addr;
      w_we    = w_cpu_wr;
      w_wdata = w_cpu_wr ? cpu_wdata : 3'd0;
    end
  end

  assign mem_addr   = reset ? '0   : w_addr;
  assign mem_we     = reset ? 1'b0 : w_we;
  assign mem_wdata  = reset ? 3'd0 : w_wdata;
  assign cpu_ack    = ~reset & w_cpu_go;
  assign cpu_rvalid = (r_state == S_RD_WAIT);
  assign cpu_rdata  = (r_state == S_RD_WAIT) ? w_rd_live : r_cpu_rdata;
  assign clr_busy   = r_clr_busy;
  assign rgb        = r_rgb;

  // Arbitration state machine: idle/CPU read wait/clear sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_clr_cnt   <= '0;
      r_clr_color <= 3'd0;
      r_clr_busy  <= 1'b0;
      r_rd_oor    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_clr_go) begin
            r_clr_color <= clr_color;
            r_clr_cnt   <= '0;
            r_clr_busy  <= 1'b1;
            r_state     <= S_CLEAR;
          end else if (w_cpu_go && !cpu_we) begin
            r_rd_oor <= ~w_cpu_in_range;
            r_state  <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          r_state <= S_IDLE;
        end
        S_CLEAR: begin
          if (w_clr_wr) begin
            if (r_clr_cnt == FB_LAST) begin
              r_clr_cnt  <= '0;
              r_clr_busy <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_clr_cnt <= r_clr_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Hold the last CPU read result after the rvalid pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cpu_rdata <= 3'd0;
    end else if (r_state == S_RD_WAIT) begin
      r_cpu_rdata <= w_rd_live;
    end
  end

  // Pixel pipeline: load RAM data the clk after a display read, blank outside the visible area.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_disp_rd <= 1'b0;
      r_rgb     <= 3'd0;
    end else begin
      r_disp_rd <= w_disp_slot;
      if (pix_en && !disp_active) begin
        r_rgb <= 3'd0;
      end else if (r_disp_rd) begin
        r_rgb <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - self-checking bench for fb_arbiter
module tb_fb_arbiter;

  localparam int H  = 640;
  localparam int V  = 8;
  localparam int AW = 19;
  localparam int FB = H * V;

  logic          clk = 1'b0;
  logic          reset;
  logic          pix_en;
  logic          disp_active;
  logic [8:0]    line;
  logic [9:0]    offset;
  logic [2:0]    rgb;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [2:0]    mem_wdata;
  logic [2:0]    mem_rdata;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [2:0]    cpu_wdata;
  logic          cpu_ack;
  logic [2:0]    cpu_rdata;
  logic          cpu_rvalid;
  logic          clr_start;
  logic [2:0]    clr_color;
  logic          clr_busy;

  fb_arbiter #(.H_RES(H), .V_RES(V), .AW(AW)) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .disp_active(disp_active),
    .line(line), .offset(offset), .rgb(rgb),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .clr_start(clr_start), .clr_color(clr_color), .clr_busy(clr_busy)
  );

  always #10 clk = ~clk;

  // Synchronous-read, read-before-write frame buffer RAM.
  logic [2:0] ram [0:524287];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model state
  logic [2:0] gold [0:FB-1];
  int         m_clr_idx = -1;
  logic [2:0] m_clr_col = 3'd0;
  bit         m_rd_wait = 1'b0;
  logic [2:0] m_rd_data = 3'd0;
  logic [2:0] m_rgb = 3'd0;
  bit         n1_v = 1'b0;
  bit         n2_v = 1'b0;
  logic [2:0] n1 = 3'd0;
  logic [2:0] n2 = 3'd0;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    pix_en = ~pix_en;
  endtask

  // Mid-cycle: compare every output with the model, then step the model.
  task automatic sample();
    bit         disp, inr, nx_rd, e_av, e_we, e_ack, e_rv, e_busy, clr_wr, clr_go;
    int         e_addr, ca;
    logic [2:0] e_wd, e_rd, nx_data;
    @(negedge clk);
    if (reset) begin
      chk("rst_rgb", rgb, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_cpu_ack", cpu_ack, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_cpu_rvalid", cpu_rvalid, 0);
      chk("rst_clr_busy", clr_busy, 0);
      m_clr_idx = -1; m_rd_wait = 0; m_rgb = 0; n1_v = 0; n2_v = 0;
      return;
    end
    if (n1_v) m_rgb = n1;
    n1_v = n2_v; n1 = n2; n2_v = 0;
    disp = pix_en && disp_active;
    ca = int'(cpu_addr);
    inr = (ca < FB);
    e_av = 0; e_we = 0; e_ack = 0; e_wd = 0; e_addr = 0;
    e_rv = m_rd_wait; e_rd = m_rd_data; e_busy = (m_clr_idx >= 0);
    nx_rd = 0; nx_data = 0; clr_wr = 0; clr_go = 0;
    if (disp) begin
      e_av = 1; e_addr = int'(line) * H + int'(offset);
    end else if (m_clr_idx >= 0) begin
      e_av = 1; e_addr = m_clr_idx; e_we = 1; e_wd = m_clr_col; clr_wr = 1;
    end else if (!m_rd_wait && clr_start) begin
      clr_go = 1;
    end else if (!m_rd_wait && cpu_req) begin
      e_ack = 1; e_av = 1; e_addr = ca;
      if (cpu_we) begin
        if (inr) begin e_we = 1; e_wd = cpu_wdata; end
      end else begin
        nx_rd = 1; nx_data = inr ? gold[ca] : 3'd0;
      end
    end
    chk("rgb", rgb, e_rgb_of(m_rgb));
    if (e_av) chk("mem_addr", mem_addr, e_addr);
    chk("mem_we", mem_we, e_we);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("cpu_ack", cpu_ack, e_ack);
    chk("cpu_rvalid", cpu_rvalid, e_rv);
    if (e_rv) chk("cpu_rdata", cpu_rdata, e_rd);
    chk("clr_busy", clr_busy, e_busy);
    if (disp) begin n2_v = 1; n2 = (e_addr < FB) ? gold[e_addr] : 3'd0; end
    if (pix_en && !disp_active) begin n1_v = 1; n1 = 3'd0; end
    if (e_we) gold[e_addr] = e_wd;
    m_rd_wait = nx_rd;
    if (nx_rd) m_rd_data = nx_data;
    if (clr_wr) m_clr_idx = (m_clr_idx == FB - 1) ? -1 : m_clr_idx + 1;
    if (clr_go) begin m_clr_idx = 0; m_clr_col = clr_color; end
  endtask

  function automatic logic [2:0] e_rgb_of(input logic [2:0] v);
    return v;
  endfunction

  task automatic wait_ack(input int bound, output bit got);
    got = 0;
    for (int i = 0; i < bound; i++) begin
      sample();
      if (cpu_ack === 1'b1) begin
        got = 1;
        return;
      end
      advance();
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit got, acked, done;
    int nwr, nbusy, last, acks_busy;

    for (int i = 0; i < 8192; i++) ram[i] = 3'($urandom);
    ram[1285] = 3'b101;
    for (int i = 0; i < FB; i++) gold[i] = ram[i];

    reset = 1; pix_en = 0; disp_active = 0; line = 0; offset = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 19'd10; cpu_wdata = 3'd7;
    clr_start = 0; clr_color = 3'd0;
    @(posedge clk); #1;
    repeat (3) begin sample(); advance(); end
    reset = 0; cpu_req = 0;
    repeat (2) begin sample(); advance(); end

    // Display read of line 2, offset 5
    disp_active = 1; line = 9'd2; offset = 10'd5;
    if (!pix_en) begin sample(); advance(); end
    sample();
    chk("disp_addr_1285", mem_addr, 1285);
    advance(); sample(); advance(); sample();
    chk("disp_rgb_101", rgb, 3'b101);
    advance();

    // CPU write during active display
    cpu_req = 1; cpu_we = 1; cpu_addr = 19'd1000; cpu_wdata = 3'b011;
    wait_ack(20, got);
    chk("wr_ack_seen", got, 1);
    if (got) begin
      chk("wr_ack_pixen", pix_en, 0);
      chk("wr_we", mem_we, 1);
      chk("wr_addr", mem_addr, 1000);
      chk("wr_wdata", mem_wdata, 3'b011);
    end
    advance(); cpu_req = 0;

    // CPU read back
    cpu_req = 1; cpu_we = 0; cpu_addr = 19'd1000;
    wait_ack(20, got);
    chk("rd_ack_seen", got, 1);
    advance(); cpu_req = 0;
    sample();
    chk("rd_rvalid", cpu_rvalid, 1);
    chk("rd_rdata_011", cpu_rdata, 3'b011);
    advance();

    // Out-of-range read
    cpu_req = 1; cpu_we = 0; cpu_addr = 19'(FB);
    wait_ack(20, got);
    chk("oor_ack_seen", got, 1);
    if (got) chk("oor_we", mem_we, 0);
    advance(); cpu_req = 0;
    sample();
    chk("oor_rvalid", cpu_rvalid, 1);
    chk("oor_rdata", cpu_rdata, 0);
    advance();

    // Clear with a CPU read of address 0 requested in the same clk
    disp_active = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 19'd0; clr_start = 1; clr_color = 3'b111;
    sample();
    chk("clr_vs_cpu_ack", cpu_ack, 0);
    advance(); clr_start = 0; clr_color = 3'd0;
    nwr = 0; nbusy = 0; last = -1; acks_busy = 0; done = 0;
    for (int c = 0; c < FB + 50 && !done; c++) begin
      sample();
      if (clr_busy) begin
        nbusy++;
        if (mem_we) begin nwr++; last = int'(mem_addr); end
        if (cpu_ack) acks_busy++;
        advance();
      end else begin
        done = 1;
      end
    end
    chk("clr_done", done, 1);
    chk("clr_busy_cycles", nbusy, FB);
    chk("clr_writes", nwr, FB);
    chk("clr_last_addr", last, FB - 1);
    chk("clr_acks_while_busy", acks_busy, 0);
    chk("clr_rgb_blank", rgb, 0);
    chk("ack_after_clear", cpu_ack, 1);
    advance(); cpu_req = 0;
    sample();
    chk("clr_rd_rvalid", cpu_rvalid, 1);
    chk("clr_rd_rdata_111", cpu_rdata, 3'b111);
    advance();

    // Reset in the middle of a clear
    clr_start = 1; clr_color = 3'b010;
    sample(); advance(); clr_start = 0;
    repeat (40) begin sample(); advance(); end
    reset = 1;
    sample();
    chk("midclr_rst_busy", clr_busy, 0);
    chk("midclr_rst_we", mem_we, 0);
    advance(); reset = 0;
    sample();
    chk("midclr_after_busy", clr_busy, 0);
    advance();

    // Reset while a CPU read is pending
    cpu_req = 1; cpu_we = 0; cpu_addr = 19'd7;
    wait_ack(20, got);
    chk("pend_ack_seen", got, 1);
    advance(); reset = 1; cpu_req = 0;
    sample();
    chk("pend_rst_rvalid", cpu_rvalid, 0);
    advance(); reset = 0;
    sample();
    chk("pend_after_rvalid", cpu_rvalid, 0);
    advance();

    // Randomized traffic
    cpu_req = 0;
    for (int c = 0; c < 4000; c++) begin
      sample();
      acked = (cpu_ack === 1'b1);
      advance();
      if ($urandom_range(0, 99) < 3) disp_active = ~disp_active;
      line = 9'($urandom_range(0, V - 1));
      offset = 10'($urandom_range(0, H - 1));
      if (!cpu_req || acked) begin
        if ($urandom_range(0, 2) == 0) begin
          cpu_req = 1;
          cpu_we = 1'($urandom);
          cpu_addr = 19'($urandom_range(0, FB + 200));
          cpu_wdata = 3'($urandom);
        end else begin
          cpu_req = 0;
        end
      end
      clr_start = ($urandom_range(0, 999) == 0);
      clr_color = 3'($urandom);
    end
    clr_start = 0; cpu_req = 0;
    sample();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_arbiter.md
Name: fb_arbiter

Overview:
- Shares one single-port, synchronous-read frame buffer between three masters: VGA scan-out, CPU read/write requests, and a built-in clear-screen engine.
- Runs at 2x the pixel clock; the pixel clock is marked by the pix_en strobe.
- Converts the VGA controller's line/offset into a linear frame-buffer address and returns 3-bit {R,G,B} pixel data.
- Sits between VGA_Controller, the frame-buffer RAM and the CPU bus.

Parameters:
- H_RES, 640, pixels per line.
- V_RES, 480, lines per frame.
- AW, 19, frame-buffer address width (must hold H_RES*V_RES-1 = 307199).

Ports:
- clk  in  1  50 MHz system clock (2x pixel clock).
- reset  in  1  asynchronous, active-high.
- pix_en  in  1  high one clk in every two; marks the display slot aligned to the VGA pixel clock edge.
- disp_active  in  1  high while VGA is in the visible region.
- line  in  9  current VGA line, 0..479.
- offset  in  10  current VGA pixel offset, 0..639.
- rgb  out  3  pixel colour to VGA r,g,b inputs.
- mem_addr  out  AW  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  3  RAM write data.
- mem_rdata  in  3  RAM read data, valid 1 clk after the address is issued.
- cpu_req  in  1  CPU request; fields held stable until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  AW  CPU linear address.
- cpu_wdata  in  3  CPU write data.
- cpu_ack  out  1  1-clk pulse: request issued to RAM.
- cpu_rdata  out  3  CPU read data.
- cpu_rvalid  out  1  1-clk pulse, 1 clk after cpu_ack on a read.
- clr_start  in  1  pulse: start clearing the whole buffer.
- clr_color  in  3  clear colour, sampled on clr_start.
- clr_busy  out  1  clear in progress.

Behaviour:
- Reset: rgb, mem_addr, mem_we, mem_wdata, cpu_ack, cpu_rdata, cpu_rvalid and clr_busy all 0; state IDLE; clear counter 0. Reset mid-clear aborts the clear; a pending CPU read returns no rvalid.
- Display address = line*H_RES + offset, computed as (line<<9)+(line<<7)+offset and truncated to AW bits. Combinational from the inputs, registered onto mem_addr.
- Slot rules, evaluated every clk:
  - Display slot: pix_en=1 and disp_active=1. Always a display read. The CPU and clear engine are not served.
  - Free slot: any other clk. Priority is clear engine (state CLEAR), then CPU.
- Display read timing: mem_rdata is registered into rgb 1 clk after the issue cycle.
  - Total latency is 2 clk (1 pixel) from the pix_en cycle to the new rgb.
  - rgb is forced to 0 on the clk after a pix_en=1 cycle with disp_active=0.
- States:
  - IDLE: in a free slot with clr_start=1, latch clr_color, counter=0, set clr_busy=1, go to CLEAR. No CPU ack that cycle; clear wins a simultaneous cpu_req. Otherwise, in a free slot with cpu_req=1, issue the CPU access and pulse cpu_ack. For a read, go to RD_WAIT.
  - RD_WAIT: capture mem_rdata into cpu_rdata, pulse cpu_rvalid, return to IDLE. This always happens in the next clk; a display read may share that clk because the RAM port is used only in the issue clk.
  - CLEAR: in each free slot, write the latched colour to the counter address and increment the counter. After writing address H_RES*V_RES-1, go to IDLE and clear clr_busy on the following clk. A clr_start seen while in CLEAR is ignored. cpu_req stalls (no ack) for the whole clear.
- CPU address >= H_RES*V_RES:
  - Still acked; mem_we stays 0.
  - A read returns cpu_rdata=0 with a normal cpu_rvalid.
- mem_we is high only in the issue clk of a CPU write or a clear write. mem_wdata=0 when mem_we=0.
- cpu_ack is never asserted in a display slot, nor on two consecutive clks for the same request. The CPU must drop cpu_req, or present the next request, on the clk after cpu_ack.

Test Plan:
- Reset, then disp_active=1, line=2, offset=5, pix_en pulsing -> mem_addr=1285 in the display slot; RAM value 3'b101 appears on rgb 2 clk after that pix_en.
- cpu_req write, addr=1000, data=3'b011, held during active display -> cpu_ack occurs only in a pix_en=0 clk; mem_we=1, mem_addr=1000, mem_wdata=3'b011 in that clk.
- CPU read, addr=1000, after the write -> cpu_ack, then cpu_rvalid=1 with cpu_rdata=3'b011 exactly 1 clk later.
- clr_start with clr_color=3'b111 and disp_active=0 -> clr_busy high for 307200 writes over consecutive clks, ending at address 307199; clr_busy=0 after; a cpu_req held during the clear is acked only after clr_busy falls. Read of address 0 returns 3'b111.
- cpu_req and clr_start in the same free clk -> no cpu_ack, clear starts; reset asserted mid-clear -> clr_busy=0 immediately and all outputs at reset values.
- CPU read of addr=307200 -> cpu_ack, mem_we=0, cpu_rvalid with cpu_rdata=0.
